// File: rtl/nes_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// nes_mem_arbiter_if
// Purpose : Bundles the PRG (CPU) port, the CHR (PPU) port and the board
//           SRAM pins of the NES memory arbiter.
// Ports   : cpu_* / ppu_*  request strobe, write flag, 22-bit translated
//                          address, mapper allow flag, write data, read data
//                          and a one-clock done pulse per port
//           mem_*          shared 8-bit SRAM address/data/strobes
//           busy           arbiter has work pending or in service
// Modports: slave  - the arbiter itself
//           master - the CPU/PPU/mapper glue and SRAM side driving it
// ----------------------------------------------------------------------------
interface nes_mem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [21:0] cpu_addr;
    logic        cpu_allow;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_done;

    logic        ppu_req;
    logic        ppu_we;
    logic [21:0] ppu_addr;
    logic        ppu_allow;
    logic [7:0]  ppu_din;
    logic [7:0]  ppu_dout;
    logic        ppu_done;

    logic [21:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_oe;
    logic        mem_we;
    logic        busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_allow, cpu_din,
        output cpu_dout, cpu_done,
        input  ppu_req, ppu_we, ppu_addr, ppu_allow, ppu_din,
        output ppu_dout, ppu_done,
        output mem_addr, mem_wdata, mem_oe, mem_we, busy,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_allow, cpu_din,
        input  cpu_dout, cpu_done,
        output ppu_req, ppu_we, ppu_addr, ppu_allow, ppu_din,
        input  ppu_dout, ppu_done,
        input  mem_addr, mem_wdata, mem_oe, mem_we, busy,
        output mem_rdata
    );
endinterface

// File: rtl/nes_mem_arbiter.sv
// ----------------------------------------------------------------------------
// nes_mem_arbiter
// Purpose : Serialises PRG (CPU) and CHR (PPU) accesses onto one shared 8-bit
//           external SRAM. Each port owns a single pending slot; a granted
//           access holds mem_oe or mem_we for ACCESS_CYCLES clocks, then the
//           port gets its read data (reads) and a one-clock done pulse.
//           Writes without the mapper allow flag, and PRG reads without it
//           (open bus), run no memory cycle and complete at arbitration.
// Ports   : clk    system clock, rising edge
//           reset  synchronous active-high reset
//           bus    nes_mem_arbiter_if.slave (CPU port, PPU port, SRAM pins)
// Params  : ACCESS_CYCLES  strobe length per access, 1..15
// Config  : ARB_ROUND_ROBIN_EN - when defined, contended arbitration
//           alternates (PPU wins the first tie); otherwise PPU always wins.
// ----------------------------------------------------------------------------
module nes_mem_arbiter #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    nes_mem_arbiter_if.slave      bus
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic        cur_ppu_r, cur_ppu_s;
    logic        mem_oe_r, mem_oe_s, mem_we_r, mem_we_s;
    logic [21:0] mem_addr_r, mem_addr_s;
    logic [7:0]  mem_wdata_r, mem_wdata_s;
    logic [7:0]  cpu_dout_r, cpu_dout_s, ppu_dout_r, ppu_dout_s;
    logic        cpu_done_r, cpu_done_s, ppu_done_r, ppu_done_s;
    logic        pend_cpu_r, pend_cpu_s, pend_ppu_r, pend_ppu_s;
    logic        cpu_cap_s, ppu_cap_s;

    // Captured request slots
    logic        cpu_we_r, cpu_allow_r, ppu_we_r, ppu_allow_r;
    logic [21:0] cpu_addr_r, ppu_addr_r;
    logic [7:0]  cpu_din_r, ppu_din_r;

    // Arbitration results
    logic        fin_s, arb_s, cand_cpu_s, cand_ppu_s, pick_ppu_s;
    logic        launch_s, blocked_s, start_s;
    logic        win_we_s, win_allow_s;
    logic [21:0] win_addr_s;
    logic [7:0]  win_din_s;

`ifdef ARB_ROUND_ROBIN_EN
    logic        last_ppu_r;
`endif

    // Arbitration: pick a winner when idle or when the current access ends
    always_comb begin
        fin_s      = (state_r == ST_ACCESS) && (cnt_r == 4'd0);
        arb_s      = (state_r == ST_IDLE) || fin_s;
        // The finishing port is excluded so only the other slot can chain in
        cand_cpu_s = arb_s && pend_cpu_r && !(fin_s && !cur_ppu_r);
        cand_ppu_s = arb_s && pend_ppu_r && !(fin_s && cur_ppu_r);
`ifdef ARB_ROUND_ROBIN_EN
        if (cand_cpu_s && cand_ppu_s) begin
            pick_ppu_s = ~last_ppu_r;
        end else begin
            pick_ppu_s = cand_ppu_s;
        end
`else
        pick_ppu_s = cand_ppu_s;
`endif
        if (pick_ppu_s) begin
            win_we_s    = ppu_we_r;
            win_allow_s = ppu_allow_r;
            win_addr_s  = ppu_addr_r;
            win_din_s   = ppu_din_r;
        end else begin
            win_we_s    = cpu_we_r;
            win_allow_s = cpu_allow_r;
            win_addr_s  = cpu_addr_r;
            win_din_s   = cpu_din_r;
        end
        launch_s = cand_cpu_s || cand_ppu_s;
        // Disallowed writes, and PRG reads without allow (open bus), skip SRAM
        if (win_we_s) begin
            blocked_s = ~win_allow_s;
        end else begin
            blocked_s = ~pick_ppu_s & ~win_allow_s;
        end
        start_s = launch_s && !blocked_s;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) state_s = ST_ACCESS;
                else         state_s = ST_IDLE;
            end
            ST_ACCESS: begin
                if (start_s)    state_s = ST_ACCESS;
                else if (fin_s) state_s = ST_IDLE;
                else            state_s = ST_ACCESS;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        if (start_s) begin
            mem_oe_s    = ~win_we_s;
            mem_we_s    = win_we_s;
            cnt_s       = CNT_LOAD;
            mem_addr_s  = win_addr_s;
            mem_wdata_s = win_din_s;
            cur_ppu_s   = pick_ppu_s;
        end else if ((state_r == ST_ACCESS) && !fin_s) begin
            mem_oe_s    = mem_oe_r;
            mem_we_s    = mem_we_r;
            cnt_s       = cnt_r - 4'd1;
            mem_addr_s  = mem_addr_r;
            mem_wdata_s = mem_wdata_r;
            cur_ppu_s   = cur_ppu_r;
        end else begin
            mem_oe_s    = 1'b0;
            mem_we_s    = 1'b0;
            cnt_s       = 4'd0;
            mem_addr_s  = mem_addr_r;
            mem_wdata_s = mem_wdata_r;
            cur_ppu_s   = cur_ppu_r;
        end

        cpu_done_s = (fin_s && !cur_ppu_r) || (launch_s && blocked_s && !pick_ppu_s);
        ppu_done_s = (fin_s && cur_ppu_r)  || (launch_s && blocked_s && pick_ppu_s);

        if (fin_s && !cur_ppu_r && mem_oe_r) cpu_dout_s = bus.mem_rdata;
        else                                  cpu_dout_s = cpu_dout_r;
        if (fin_s && cur_ppu_r && mem_oe_r)  ppu_dout_s = bus.mem_rdata;
        else                                  ppu_dout_s = ppu_dout_r;

        // A slot accepts a new request only when free or completing this edge
        cpu_cap_s = bus.cpu_req && (!pend_cpu_r || cpu_done_s);
        ppu_cap_s = bus.ppu_req && (!pend_ppu_r || ppu_done_s);
        if (cpu_cap_s)       pend_cpu_s = 1'b1;
        else if (cpu_done_s) pend_cpu_s = 1'b0;
        else                 pend_cpu_s = pend_cpu_r;
        if (ppu_cap_s)       pend_ppu_s = 1'b1;
        else if (ppu_done_s) pend_ppu_s = 1'b0;
        else                 pend_ppu_s = pend_ppu_r;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            cur_ppu_r   <= 1'b0;
            mem_oe_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 22'd0;
            mem_wdata_r <= 8'd0;
            cpu_dout_r  <= 8'hFF;
            ppu_dout_r  <= 8'hFF;
            cpu_done_r  <= 1'b0;
            ppu_done_r  <= 1'b0;
            pend_cpu_r  <= 1'b0;
            pend_ppu_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            cur_ppu_r   <= cur_ppu_s;
            mem_oe_r    <= mem_oe_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            cpu_dout_r  <= cpu_dout_s;
            ppu_dout_r  <= ppu_dout_s;
            cpu_done_r  <= cpu_done_s;
            ppu_done_r  <= ppu_done_s;
            pend_cpu_r  <= pend_cpu_s;
            pend_ppu_r  <= pend_ppu_s;
        end
    end

    // Request slot capture
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_we_r <= 1'b0; cpu_allow_r <= 1'b0; cpu_addr_r <= 22'd0; cpu_din_r <= 8'd0;
            ppu_we_r <= 1'b0; ppu_allow_r <= 1'b0; ppu_addr_r <= 22'd0; ppu_din_r <= 8'd0;
        end else begin
            if (cpu_cap_s) begin
                cpu_we_r <= bus.cpu_we; cpu_allow_r <= bus.cpu_allow;
                cpu_addr_r <= bus.cpu_addr; cpu_din_r <= bus.cpu_din;
            end else begin
                cpu_we_r <= cpu_we_r;
            end
            if (ppu_cap_s) begin
                ppu_we_r <= bus.ppu_we; ppu_allow_r <= bus.ppu_allow;
                ppu_addr_r <= bus.ppu_addr; ppu_din_r <= bus.ppu_din;
            end else begin
                ppu_we_r <= ppu_we_r;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember the winner of the last contended arbitration
    always_ff @(posedge clk) begin
        if (reset) begin
            last_ppu_r <= 1'b0;
        end else if (cand_cpu_s && cand_ppu_s) begin
            last_ppu_r <= pick_ppu_s;
        end else begin
            last_ppu_r <= last_ppu_r;
        end
    end
`endif

    assign bus.mem_oe    = mem_oe_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.cpu_dout  = cpu_dout_r;
    assign bus.ppu_dout  = ppu_dout_r;
    assign bus.cpu_done  = cpu_done_r;
    assign bus.ppu_done  = ppu_done_r;
    assign bus.busy      = pend_cpu_r | pend_ppu_r | (state_r != ST_IDLE);

endmodule

// File: tb/tb_nes_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_nes_mem_arbiter
// Purpose : Directed self-checking bench for nes_mem_arbiter with
//           ACCESS_CYCLES=2. Inputs change 1 time unit after a rising edge and
//           outputs are sampled at the same point, so "cycle N" below is the
//           clock period following the edge that captured the request.
// ----------------------------------------------------------------------------
module tb_nes_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cnt_a;
    int   cnt_b;

    nes_mem_arbiter_if bus();

    nes_mem_arbiter #(.ACCESS_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_drive(input logic we, input logic allow, input logic [21:0] addr,
                             input logic [7:0] din);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_allow = allow;
        bus.cpu_addr = addr; bus.cpu_din = din;
    endtask

    task automatic ppu_drive(input logic we, input logic allow, input logic [21:0] addr,
                             input logic [7:0] din);
        bus.ppu_req = 1'b1; bus.ppu_we = we; bus.ppu_allow = allow;
        bus.ppu_addr = addr; bus.ppu_din = din;
    endtask

    task automatic drop_reqs();
        bus.cpu_req = 1'b0;
        bus.ppu_req = 1'b0;
    endtask

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_allow = 1'b0;
        bus.cpu_addr = 22'd0; bus.cpu_din = 8'd0;
        bus.ppu_req = 1'b0; bus.ppu_we = 1'b0; bus.ppu_allow = 1'b0;
        bus.ppu_addr = 22'd0; bus.ppu_din = 8'd0;
        bus.mem_rdata = 8'h00;

        // Reset state
        tick(); tick();
        check("rst_oe", bus.mem_oe, 1'b0);
        check("rst_we", bus.mem_we, 1'b0);
        check("rst_done", {bus.cpu_done, bus.ppu_done}, 2'b00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_dout", {bus.cpu_dout, bus.ppu_dout}, 16'hFFFF);
        check("rst_addr", bus.mem_addr, 22'd0);
        check("rst_wdata", bus.mem_wdata, 8'd0);
        reset = 1'b0;
        tick();

        // PPU read
        ppu_drive(1'b0, 1'b1, 22'h200010, 8'h00);
        bus.mem_rdata = 8'h5A;
        tick(); drop_reqs();                                   // cycle N
        check("rd_busy_N", bus.busy, 1'b1);
        check("rd_oe_N", bus.mem_oe, 1'b0);
        tick();                                                // N+1
        check("rd_oe_N1", bus.mem_oe, 1'b1);
        check("rd_addr_N1", bus.mem_addr, 22'h200010);
        tick();                                                // N+2
        check("rd_oe_N2", bus.mem_oe, 1'b1);
        check("rd_done_N2", bus.ppu_done, 1'b0);
        tick();                                                // N+3
        check("rd_oe_N3", bus.mem_oe, 1'b0);
        check("rd_done_N3", bus.ppu_done, 1'b1);
        check("rd_dout", bus.ppu_dout, 8'h5A);
        check("rd_cpu_dout", bus.cpu_dout, 8'hFF);
        tick();                                                // N+4
        check("rd_done_N4", bus.ppu_done, 1'b0);
        check("rd_busy_N4", bus.busy, 1'b0);

        // CPU write
        cpu_drive(1'b1, 1'b1, 22'h000123, 8'h3C);
        tick(); drop_reqs();
        tick();
        check("wr_we_N1", bus.mem_we, 1'b1);
        check("wr_oe_N1", bus.mem_oe, 1'b0);
        check("wr_addr", bus.mem_addr, 22'h000123);
        check("wr_wdata", bus.mem_wdata, 8'h3C);
        tick();
        check("wr_we_N2", bus.mem_we, 1'b1);
        tick();
        check("wr_we_N3", bus.mem_we, 1'b0);
        check("wr_done_N3", bus.cpu_done, 1'b1);
        check("wr_cpu_dout", bus.cpu_dout, 8'hFF);
        tick();

        // CPU read to give cpu_dout a known value
        cpu_drive(1'b0, 1'b1, 22'h000200, 8'h00);
        bus.mem_rdata = 8'hA5;
        tick(); drop_reqs();
        tick(); tick(); tick();
        check("crd_done", bus.cpu_done, 1'b1);
        check("crd_dout", bus.cpu_dout, 8'hA5);
        tick();

        // Blocked write: no SRAM cycle, one done one clock after capture
        cpu_drive(1'b1, 1'b0, 22'h000055, 8'h77);
        bus.mem_rdata = 8'h99;
        tick(); drop_reqs();
        check("blk_done_N", bus.cpu_done, 1'b0);
        tick();
        check("blk_done_N1", bus.cpu_done, 1'b1);
        cnt_a = 0; cnt_b = 1;
        for (int i = 0; i < 5; i++) begin
            if (bus.mem_we) cnt_a++;
            tick();
            if (bus.cpu_done) cnt_b++;
        end
        check("blk_we_cnt", cnt_a, 0);
        check("blk_done_cnt", cnt_b, 1);
        check("blk_dout", bus.cpu_dout, 8'hA5);
        check("blk_busy", bus.busy, 1'b0);

        // Contention: PPU first, CPU chained with no gap
        cpu_drive(1'b0, 1'b1, 22'h000300, 8'h00);
        ppu_drive(1'b0, 1'b1, 22'h200300, 8'h00);
        bus.mem_rdata = 8'h11;
        tick(); drop_reqs();
        tick();                                                // N+1
        check("ct_addr_N1", bus.mem_addr, 22'h200300);
        check("ct_oe_N1", bus.mem_oe, 1'b1);
        tick(); tick();                                        // N+3
        check("ct_ppu_done", bus.ppu_done, 1'b1);
        check("ct_ppu_dout", bus.ppu_dout, 8'h11);
        check("ct_addr_N3", bus.mem_addr, 22'h000300);
        check("ct_oe_N3", bus.mem_oe, 1'b1);
        bus.mem_rdata = 8'h22;
        tick();                                                // N+4
        check("ct_cpu_done_N4", bus.cpu_done, 1'b0);
        tick();                                                // N+5
        check("ct_cpu_done_N5", bus.cpu_done, 1'b1);
        check("ct_cpu_dout", bus.cpu_dout, 8'h22);
        check("ct_ppu_dout_hold", bus.ppu_dout, 8'h11);
        tick();

        // Second contention
        cpu_drive(1'b0, 1'b1, 22'h000400, 8'h00);
        ppu_drive(1'b0, 1'b1, 22'h200400, 8'h00);
        bus.mem_rdata = 8'h33;
        tick(); drop_reqs();
        tick();
`ifdef ARB_ROUND_ROBIN_EN
        check("ct2_first", bus.mem_addr, 22'h000400);
`else
        check("ct2_first", bus.mem_addr, 22'h200400);
`endif
        tick(); tick();
`ifdef ARB_ROUND_ROBIN_EN
        check("ct2_second", bus.mem_addr, 22'h200400);
`else
        check("ct2_second", bus.mem_addr, 22'h000400);
`endif
        tick(); tick(); tick();
        check("ct2_busy", bus.busy, 1'b0);

        // Repeat request while in service is ignored
        cpu_drive(1'b1, 1'b1, 22'h000010, 8'h01);
        tick();
        cpu_drive(1'b1, 1'b1, 22'h000777, 8'hEE);
        tick(); drop_reqs();
        check("rep_addr", bus.mem_addr, 22'h000010);
        check("rep_wdata", bus.mem_wdata, 8'h01);
        cnt_a = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.cpu_done) cnt_a++;
        end
        check("rep_done_cnt", cnt_a, 1);
        check("rep_busy", bus.busy, 1'b0);

        // Request on the same edge as its port's done is captured
        cpu_drive(1'b1, 1'b1, 22'h000010, 8'h01);
        tick(); drop_reqs();                                   // N
        tick(); tick();                                        // N+2
        cpu_drive(1'b1, 1'b1, 22'h000020, 8'h02);
        tick(); drop_reqs();                                   // N+3
        check("b2b_done1", bus.cpu_done, 1'b1);
        check("b2b_we_gap", bus.mem_we, 1'b0);
        check("b2b_busy", bus.busy, 1'b1);
        tick();                                                // N+4
        check("b2b_we2", bus.mem_we, 1'b1);
        check("b2b_addr2", bus.mem_addr, 22'h000020);
        tick(); tick();                                        // N+6
        check("b2b_done2", bus.cpu_done, 1'b1);
        tick();

        // Reset in the middle of a read
        ppu_drive(1'b0, 1'b1, 22'h200050, 8'h00);
        bus.mem_rdata = 8'h44;
        tick(); drop_reqs();
        tick();                                                // N+1
        check("mr_oe_N1", bus.mem_oe, 1'b1);
        reset = 1'b1;
        tick();                                                // N+2
        check("mr_oe_N2", bus.mem_oe, 1'b0);
        check("mr_busy", bus.busy, 1'b0);
        check("mr_done", {bus.cpu_done, bus.ppu_done}, 2'b00);
        check("mr_dout", {bus.cpu_dout, bus.ppu_dout}, 16'hFFFF);
        reset = 1'b0;
        tick(); tick();
        check("mr_after_done", bus.ppu_done, 1'b0);
        check("mr_after_oe", bus.mem_oe, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
